// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// default operand width and the step-counter width helper.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic           unused_p_msb;

  // P < divisor holds between steps, so its top bit is always clear.
  assign unused_p_msb = p[WIDTH];
  assign shifted      = {p[WIDTH-1:0], q_msb};

  always_comb begin
    p_next = shifted;
    q_bit  = 1'b0;
    if (shifted >= {1'b0, divisor}) begin
      p_next = shifted - {1'b0, divisor};
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN adds div_zero and a one-cycle B==0 fast path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
`ifdef DIV_ZERO_DETECT_EN
  output logic [WIDTH-1:0] R,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] R
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH:0]   p_q, p_nx;
  logic [WIDTH-1:0] qs_q, bd_q, qs_nx;
  logic [CW-1:0]    cnt_q;
  logic             q_bit, last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p_q),
    .q_msb   (qs_q[WIDTH-1]),
    .divisor (bd_q),
    .p_next  (p_nx),
    .q_bit   (q_bit)
  );

  assign qs_nx     = {qs_q[WIDTH-2:0], q_bit};
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) begin
`ifdef DIV_ZERO_DETECT_EN
        state_nx = (B == '0) ? ST_DONE : ST_CALC;
`else
        state_nx = ST_CALC;
`endif
      end
      ST_CALC: if (last_step) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Results are written once per operation and held until the next one lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      qs_q  <= '0;
      bd_q  <= '0;
      cnt_q <= '0;
      Q     <= '0;
      R     <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          qs_q  <= A;
          bd_q  <= B;
          p_q   <= '0;
          cnt_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
          if (B == '0) begin
            Q        <= '1;
            R        <= A;
            div_zero <= 1'b1;
          end
`endif
        end
        ST_CALC: begin
          p_q   <= p_nx;
          qs_q  <= qs_nx;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            Q <= qs_nx;
            R <= p_nx[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): latency, busy, results, ignored
// starts, mid-operation reset and an exhaustive back-to-back sweep.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B, Q, R;
  logic         busy, done;
`ifdef DIV_ZERO_DETECT_EN
  logic         div_zero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
`ifdef DIV_ZERO_DETECT_EN
    .R     (R),
    .div_zero (div_zero)
`else
    .R     (R)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts cycles from the current negedge until done is seen (bounded).
  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue an operation at the current (IDLE) negedge and check it through to
  // the IDLE cycle after done, where the next start may be applied.
  task automatic run_op(input string tag, input int a, input int b,
                        input int exp_q, input int exp_r, input int exp_lat);
    int lat, bsy;
    start = 1'b1; A = W'(a); B = W'(b);
    @(negedge clk);
    start = 1'b0; A = W'(~a); B = W'(~b);
    wait_done(lat, bsy);
    chk({tag, "_latency"}, lat + 1, exp_lat);
    chk({tag, "_busy_cycles"}, bsy, exp_lat - 1);
    chk({tag, "_q"}, int'(Q), exp_q);
    chk({tag, "_r"}, int'(R), exp_r);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_q_held"}, int'(Q), exp_q);
  endtask

  initial begin
    int lat, bsy, seen_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_q", int'(Q), 0);
    chk("reset_r", int'(R), 0);
`ifdef DIV_ZERO_DETECT_EN
    chk("reset_div_zero", int'(div_zero), 0);
`endif
    rst = 1'b0;

    run_op("t1_13_3", 13, 3, 4, 1, 5);
    run_op("t2_15_1", 15, 1, 15, 0, 5);
    run_op("t2_2_7", 2, 7, 0, 2, 5);
    run_op("t2_0_5", 0, 5, 0, 0, 5);
`ifdef DIV_ZERO_DETECT_EN
    run_op("t3_9_0", 9, 0, 15, 9, 1);
    // div_zero is held with the result; expect it after the done cycle too
    chk("t3_div_zero", int'(div_zero), 1);
    run_op("t3_after_6_3", 6, 3, 2, 0, 5);
    chk("t3_div_zero_clear", int'(div_zero), 0);
`else
    run_op("t3_9_0", 9, 0, 15, 9, 5);
`endif

    // Start pulsed mid-calculation with new operands must be ignored.
    start = 1'b1; A = 4'd14; B = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bsy);
    chk("t4_latency", lat + 3, 5);
    chk("t4_q", int'(Q), 3);
    chk("t4_r", int'(R), 2);
    @(negedge clk);
    chk("t4_idle_after", int'(busy) + int'(done), 0);

    // Reset two cycles into CALC aborts without a done pulse.
    start = 1'b1; A = 4'd11; B = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_q", int'(Q), 0);
    chk("t5_r", int'(R), 0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("t5_no_done", seen_done, 0);
    run_op("t5_7_2", 7, 2, 3, 1, 5);

    // Exhaustive sweep, each start in the IDLE cycle right after done.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        start = 1'b1; A = W'(a); B = W'(b);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bsy);
        checks++;
        assert (lat + 1 == 5 && int'(Q) == a / b && int'(R) == a % b &&
                int'(Q) * b + int'(R) == a && int'(R) < b) else begin
          failures++;
          $error("FAIL sweep_%0d_%0d: observed q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=5",
                 a, b, Q, R, lat + 1, a / b, a % b);
        end
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
